// File: rtl/stim_gen.sv
// stim_gen: pseudo-random stimulus source for a measured/reference compare path.
// A 64-bit Galois LFSR supplies signed stimulus words. data_valid is also
// delayed by DELAY cycles to give exp_valid, which tells the downstream
// monitor when the circuit under test should produce each result.
// The bench-only macro STIM_CORNER_EN makes the first four words
// 0, -1, max positive and min negative before the LFSR stream begins.
module stim_gen #(
  parameter int          DATAWIDTH   = 32,
  parameter logic [63:0] SEED        = 64'h0123456789ABCDEF,
  parameter int          NUM_VECTORS = 1000,
  parameter int          DELAY       = 2
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic                        En,
  output logic signed [DATAWIDTH-1:0] data,
  output logic                        data_valid,
  output logic                        exp_valid,
  output logic [31:0]                 count,
  output logic                        done
);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  // An all-zero state would lock the LFSR, so a zero seed is replaced by 1.
  localparam logic [63:0] SEED_EFF = (SEED == 64'd0) ? 64'd1 : SEED;
  localparam logic [63:0] POLY     = 64'hD800000000000000;
  localparam logic [31:0] LAST_CNT = 32'(NUM_VECTORS - 1);

  state_t                 state, state_nxt;
  logic [63:0]            lfsr, lfsr_nxt;
  logic [DATAWIDTH-1:0]   word;
  logic                   issue;
  logic                   adv;
  logic                   fin;
  // vld_pipe[0] is data_valid itself; vld_pipe[DELAY] is exp_valid.
  logic [DELAY:0]         vld_pipe;

  assign lfsr_nxt   = {1'b0, lfsr[63:1]} ^ (lfsr[0] ? POLY : 64'd0);
  assign data_valid = vld_pipe[0];
  assign exp_valid  = vld_pipe[DELAY];

`ifdef STIM_CORNER_EN
  localparam logic [DATAWIDTH-1:0] ONE     = DATAWIDTH'(1);
  localparam logic [DATAWIDTH-1:0] MIN_NEG = ONE << (DATAWIDTH - 1);
  localparam logic [DATAWIDTH-1:0] MAX_POS = ~MIN_NEG;

  // Counts the corner words issued so far; reaching 4 hands over to the LFSR.
  logic [2:0] corner_idx;

  // Step through the corner words, once per issued vector.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)
      corner_idx <= 3'd0;
    else if (issue && corner_idx != 3'd4)
      corner_idx <= corner_idx + 3'd1;
  end

  // Choose between a corner word (LFSR held) and the LFSR word.
  always_comb begin
    word = lfsr[DATAWIDTH-1:0];
    adv  = 1'b1;
    if (corner_idx != 3'd4) begin
      adv = 1'b0;
      case (corner_idx)
        3'd0:    word = '0;
        3'd1:    word = '1;
        3'd2:    word = MAX_POS;
        default: word = MIN_NEG;
      endcase
    end
  end
`else
  // Every issued word comes straight from the LFSR.
  always_comb begin
    word = lfsr[DATAWIDTH-1:0];
    adv  = 1'b1;
  end
`endif

  // State register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Next-state and issue decision. DRAIN waits until no beat is left anywhere
  // in the valid pipe, so done rises only after the last exp_valid has gone.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    fin       = 1'b0;
    case (state)
      RUN: begin
        if (En) begin
          issue = 1'b1;
          if (count == LAST_CNT) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (vld_pipe == '0) begin
          state_nxt = DONE;
          fin       = 1'b1;
        end
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = RUN;
    endcase
  end

  // Datapath: stimulus word, LFSR, vector count and the sticky done flag.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      data  <= '0;
      lfsr  <= SEED_EFF;
      count <= 32'd0;
      done  <= 1'b0;
    end else begin
      if (issue) begin
        data  <= word;
        count <= count + 32'd1;
        if (adv) lfsr <= lfsr_nxt;
      end
      if (fin) done <= 1'b1;
    end
  end

  // Valid delay line. Reset clears in-flight beats so none are emitted.
  generate
    if (DELAY == 0) begin : g_nodly
      always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) vld_pipe <= '0;
        else     vld_pipe <= issue;
      end
    end else begin : g_dly
      always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) vld_pipe <= '0;
        else     vld_pipe <= {vld_pipe[DELAY-1:0], issue};
      end
    end
  endgenerate

endmodule

// File: tb/tb_stim_gen.sv
// tb_stim_gen: scoreboard bench for stim_gen. Four instances share the clock,
// reset and enable: default, NUM_VECTORS=3, SEED=0/64-bit, and 8-bit.
// Builds with or without STIM_CORNER_EN.
module tb_stim_gen;

  localparam logic [63:0] DSEED = 64'h0123456789ABCDEF;

  logic        Clk;
  logic        Rst;
  logic        En;

  logic [31:0] d_data, n_data;
  logic [63:0] s_data;
  logic [7:0]  c_data;
  logic        d_dv, n_dv, s_dv, c_dv;
  logic        d_ev, n_ev, s_ev, c_ev;
  logic [31:0] d_count, n_count, s_count, c_count;
  logic        d_done, n_done, s_done, c_done;

  int checks   = 0;
  int failures = 0;

  // Scoreboard state per instance: 0=def 1=n3 2=s0 3=c8
  logic [63:0] q_d[$];
  logic [63:0] q_n[$];
  logic [63:0] q_s[$];
  logic [63:0] q_c[$];
  int          iss  [4];
  int          lastk[4];
  bit   [2:0]  sh   [4];
  int          nmax [4];
  int          wid  [4];
  logic [63:0] seeds[4];
  int          edge_n;

  stim_gen u_def (
    .Clk(Clk), .Rst(Rst), .En(En), .data(d_data), .data_valid(d_dv),
    .exp_valid(d_ev), .count(d_count), .done(d_done));

  stim_gen #(.NUM_VECTORS(3), .DELAY(2)) u_n3 (
    .Clk(Clk), .Rst(Rst), .En(En), .data(n_data), .data_valid(n_dv),
    .exp_valid(n_ev), .count(n_count), .done(n_done));

  stim_gen #(.DATAWIDTH(64), .SEED(64'd0)) u_s0 (
    .Clk(Clk), .Rst(Rst), .En(En), .data(s_data), .data_valid(s_dv),
    .exp_valid(s_ev), .count(s_count), .done(s_done));

  stim_gen #(.DATAWIDTH(8)) u_c8 (
    .Clk(Clk), .Rst(Rst), .En(En), .data(c_data), .data_valid(c_dv),
    .exp_valid(c_ev), .count(c_count), .done(c_done));

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic logic [63:0] lstep(input logic [63:0] s);
    return (s >> 1) ^ (s[0] ? 64'hD800000000000000 : 64'd0);
  endfunction

  // idx-th issued vector (0-based) for a given seed and width.
  function automatic logic [63:0] exp_vec(input logic [63:0] seed, input int w, input int idx);
    logic [63:0] s;
    logic [63:0] m;
    int          n;
    s = (seed == 64'd0) ? 64'd1 : seed;
    m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    n = idx;
`ifdef STIM_CORNER_EN
    if (idx == 0) return 64'd0;
    if (idx == 1) return m;
    if (idx == 2) return m >> 1;
    if (idx == 3) return (m >> 1) + 64'd1;
    n = idx - 4;
`endif
    for (int k = 0; k < n; k++) s = lstep(s);
    return s & m;
  endfunction

  task automatic model_reset();
    q_d.delete(); q_n.delete(); q_s.delete(); q_c.delete();
    for (int i = 0; i < 4; i++) begin
      iss[i] = 0; lastk[i] = 0; sh[i] = 3'b000;
    end
    edge_n = 0;
  endtask

  // Pulse reset and release it on a falling edge.
  task automatic apply_reset();
    Rst = 1'b1;
    En  = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    model_reset();
    Rst = 1'b0;
  endtask

  // Drive En for one rising edge, record what each instance should issue,
  // and return on the following falling edge.
  task automatic tick(input bit e);
    En = e;
    @(posedge Clk);
    edge_n++;
    for (int i = 0; i < 4; i++) begin
      bit          now;
      logic [63:0] v;
      now = e && (iss[i] < nmax[i]);
      if (now) begin
        v = exp_vec(seeds[i], wid[i], iss[i]);
        case (i)
          0: q_d.push_back(v);
          1: q_n.push_back(v);
          2: q_s.push_back(v);
          default: q_c.push_back(v);
        endcase
        iss[i]++;
        lastk[i] = edge_n;
      end
      sh[i] = {sh[i][1:0], now};
    end
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    En  = 1'b0;
    repeat (10) @(negedge Clk);
    checks++; if (d_data !== 32'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", d_data); end
    checks++; if (d_dv !== 1'b0) begin failures++; $display("FAIL reset_dv got=%b exp=0", d_dv); end
    checks++; if (d_ev !== 1'b0) begin failures++; $display("FAIL reset_ev got=%b exp=0", d_ev); end
    checks++; if (d_count !== 32'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", d_count); end
    checks++; if (d_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", d_done); end
    checks++; if (n_done !== 1'b0 || s_data !== 64'd0) begin failures++; $display("FAIL reset_other n_done=%b s_data=%h exp=0", n_done, s_data); end
    model_reset();
    Rst = 1'b0;  // released at 100 ns on a falling edge
  endtask

  task automatic test_stream();
    logic [63:0] e;
    for (int k = 1; k <= 8; k++) begin
      tick(1'b1);
      checks++; if (d_dv !== sh[0][0]) begin failures++; $display("FAIL stream_dv k=%0d got=%b exp=%b", k, d_dv, sh[0][0]); end
      checks++; if (d_ev !== sh[0][2]) begin failures++; $display("FAIL stream_ev k=%0d got=%b exp=%b", k, d_ev, sh[0][2]); end
      checks++; if (d_count !== 32'(iss[0])) begin failures++; $display("FAIL stream_count k=%0d got=%0d exp=%0d", k, d_count, iss[0]); end
      if (d_dv === 1'b1) begin
        checks++;
        if (q_d.size() == 0) begin failures++; $display("FAIL stream_data k=%0d got=%h exp=<none>", k, d_data); end
        else begin e = q_d.pop_front(); if (64'(d_data) !== e) begin failures++; $display("FAIL stream_data k=%0d got=%h exp=%h", k, d_data, e); end end
      end
      if (s_dv === 1'b1) begin
        checks++;
        if (q_s.size() == 0) begin failures++; $display("FAIL seed0_data k=%0d got=%h exp=<none>", k, s_data); end
        else begin e = q_s.pop_front(); if (s_data !== e) begin failures++; $display("FAIL seed0_data k=%0d got=%h exp=%h", k, s_data, e); end end
      end
      if (c_dv === 1'b1) begin
        checks++;
        if (q_c.size() == 0) begin failures++; $display("FAIL w8_data k=%0d got=%h exp=<none>", k, c_data); end
        else begin e = q_c.pop_front(); if (64'(c_data) !== e) begin failures++; $display("FAIL w8_data k=%0d got=%h exp=%h", k, c_data, e); end end
      end
`ifndef STIM_CORNER_EN
      if (k == 1) begin
        checks++; if (d_data !== 32'h89ABCDEF) begin failures++; $display("FAIL first_vec got=%h exp=89abcdef", d_data); end
      end
      if (k == 2) begin
        checks++; if (d_data !== 32'hC4D5E6F7 || d_count !== 32'd2) begin failures++; $display("FAIL second_vec got=%h/%0d exp=c4d5e6f7/2", d_data, d_count); end
      end
`endif
    end
  endtask

  task automatic test_pause();
    logic [63:0] e;
    apply_reset();
    for (int k = 1; k <= 8; k++) begin
      tick((k >= 2 && k <= 4) ? 1'b0 : 1'b1);
      checks++; if (d_dv !== sh[0][0]) begin failures++; $display("FAIL pause_dv k=%0d got=%b exp=%b", k, d_dv, sh[0][0]); end
      checks++; if (d_ev !== sh[0][2]) begin failures++; $display("FAIL pause_ev k=%0d got=%b exp=%b", k, d_ev, sh[0][2]); end
      if (k >= 2 && k <= 4) begin
        e = exp_vec(DSEED, 32, 0);
        checks++; if (64'(d_data) !== e) begin failures++; $display("FAIL pause_hold k=%0d got=%h exp=%h", k, d_data, e); end
      end
      if (k == 5) begin
        e = exp_vec(DSEED, 32, 1);
        checks++; if (64'(d_data) !== e) begin failures++; $display("FAIL pause_resume got=%h exp=%h", d_data, e); end
      end
      if (d_dv === 1'b1) begin
        checks++;
        if (q_d.size() == 0) begin failures++; $display("FAIL pause_data k=%0d got=%h exp=<none>", k, d_data); end
        else begin e = q_d.pop_front(); if (64'(d_data) !== e) begin failures++; $display("FAIL pause_data k=%0d got=%h exp=%h", k, d_data, e); end end
      end
    end
  endtask

  task automatic test_midreset();
    logic [63:0] e;
    apply_reset();
    repeat (5) tick(1'b1);
    checks++; if (d_count !== 32'd5) begin failures++; $display("FAIL midrst_pre_count got=%0d exp=5", d_count); end
    #2 Rst = 1'b1;
    #1;
    checks++; if (d_data !== 32'd0 || d_dv !== 1'b0 || d_ev !== 1'b0) begin failures++; $display("FAIL midrst_async data=%h dv=%b ev=%b exp=0/0/0", d_data, d_dv, d_ev); end
    checks++; if (d_count !== 32'd0 || d_done !== 1'b0) begin failures++; $display("FAIL midrst_async_cnt count=%0d done=%b exp=0/0", d_count, d_done); end
    @(negedge Clk);
    model_reset();
    Rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick(1'b1);
      checks++; if (d_ev !== sh[0][2]) begin failures++; $display("FAIL midrst_ev k=%0d got=%b exp=%b", k, d_ev, sh[0][2]); end
      checks++;
      if (q_d.size() == 0) begin failures++; $display("FAIL midrst_data k=%0d got=%h exp=<none>", k, d_data); end
      else begin e = q_d.pop_front(); if (64'(d_data) !== e) begin failures++; $display("FAIL midrst_data k=%0d got=%h exp=%h", k, d_data, e); end end
    end
  endtask

  // NUM_VECTORS=3 with a pause before the final vector and En dropped in DRAIN.
  // The last exp_valid beat is visible after edge L+2, leaves at L+3, and
  // done rises on edge L+4 (L = edge that issued the last vector).
  task automatic test_drain();
    logic [63:0] e;
    bit          en_pat [11];
    bit          xdone;
    en_pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    apply_reset();
    for (int k = 1; k <= 11; k++) begin
      tick(en_pat[k-1]);
      xdone = (iss[1] == 3) && (edge_n >= lastk[1] + 4);
      checks++; if (n_dv !== sh[1][0]) begin failures++; $display("FAIL drain_dv k=%0d got=%b exp=%b", k, n_dv, sh[1][0]); end
      checks++; if (n_ev !== sh[1][2]) begin failures++; $display("FAIL drain_ev k=%0d got=%b exp=%b", k, n_ev, sh[1][2]); end
      checks++; if (n_count !== 32'(iss[1])) begin failures++; $display("FAIL drain_count k=%0d got=%0d exp=%0d", k, n_count, iss[1]); end
      checks++; if (n_done !== xdone) begin failures++; $display("FAIL drain_done k=%0d got=%b exp=%b", k, n_done, xdone); end
      if (n_dv === 1'b1) begin
        checks++;
        if (q_n.size() == 0) begin failures++; $display("FAIL drain_data k=%0d got=%h exp=<none>", k, n_data); end
        else begin e = q_n.pop_front(); if (64'(n_data) !== e) begin failures++; $display("FAIL drain_data k=%0d got=%h exp=%h", k, n_data, e); end end
      end
      if (k == 11) begin
        e = exp_vec(DSEED, 32, 2);
        checks++; if (64'(n_data) !== e || n_count !== 32'd3) begin failures++; $display("FAIL drain_hold got=%h/%0d exp=%h/3", n_data, n_count, e); end
      end
    end
  endtask

  task automatic test_corner();
    logic [7:0] ctab [6];
`ifdef STIM_CORNER_EN
    ctab = '{8'h00, 8'hFF, 8'h7F, 8'h80, 8'hEF, 8'hF7};
`else
    ctab = '{8'hEF, 8'hF7, 8'h7B, 8'hBD, 8'hDE, 8'h6F};
`endif
    apply_reset();
    for (int k = 1; k <= 6; k++) begin
      tick(1'b1);
      checks++; if (c_data !== ctab[k-1]) begin failures++; $display("FAIL w8_seq k=%0d got=%h exp=%h", k, c_data, ctab[k-1]); end
`ifndef STIM_CORNER_EN
      if (k == 1) begin
        checks++; if (s_data !== 64'h1) begin failures++; $display("FAIL seed0_first got=%h exp=1", s_data); end
      end
      if (k == 2) begin
        checks++; if (s_data !== 64'hD800000000000000) begin failures++; $display("FAIL seed0_second got=%h exp=d800000000000000", s_data); end
      end
`endif
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      nmax[i] = 1000; wid[i] = 32; seeds[i] = DSEED;
    end
    nmax[1] = 3;
    wid[2]  = 64; seeds[2] = 64'd0;
    wid[3]  = 8;
    model_reset();
    test_reset();
    test_stream();
    test_pause();
    test_midreset();
    test_drain();
    test_corner();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stim_gen.md
Name: stim_gen

Overview:
- Self-checking bench source block: the transmit end of the measured/reference comparison path.
- Emits a deterministic pseudo-random signed stimulus word stream from a 64-bit Galois LFSR.
- Emits a matching expected-valid strobe delayed by the circuit-under-test latency, for a downstream serror_monitor.
- Counts issued vectors and flags completion once the last expected-valid strobe has drained.

Parameters:
- DATAWIDTH, 32: stimulus word width, legal range 1..64.
- SEED, 64'h0123456789ABCDEF: LFSR initial state. A value of 0 is replaced by 1.
- NUM_VECTORS, 1000: number of vectors issued before stopping. Must be at least 1.
- DELAY, 2: cycles from a data_valid beat to the matching exp_valid beat. Legal range 0..15.

Ports:
- Clk, input, 1: rising-edge clock.
- Rst, input, 1: asynchronous active-high reset.
- En, input, 1: issue enable. Low pauses the stream.
- data, output, DATAWIDTH: signed stimulus word.
- data_valid, output, 1: data holds a new vector this cycle.
- exp_valid, output, 1: data_valid delayed DELAY cycles. Drives the monitor valid input.
- count, output, 32: number of vectors issued so far.
- done, output, 1: all vectors issued and the exp_valid pipe is empty. Sticky.

Behaviour:
- Reset (asynchronous, active-high) sets:
  - data=0, data_valid=0, exp_valid=0, count=0, done=0
  - LFSR=SEED (or 1 if SEED is 0)
  - state=RUN
  - delay pipe cleared
- States: RUN, DRAIN, DONE.
- RUN, on an edge with En=1:
  - data <= LFSR[DATAWIDTH-1:0]
  - data_valid <= 1
  - count <= count+1
  - LFSR advances one step
- RUN, on an edge with En=0:
  - data_valid <= 0
  - data, count and LFSR hold
- RUN -> DRAIN on the edge that issues vector NUM_VECTORS, i.e. count becomes NUM_VECTORS.
- DRAIN:
  - data_valid <= 0, data holds, En is ignored.
  - Stays in DRAIN until every delay-pipe stage is 0.
  - Then -> DONE with done <= 1 on that edge.
- DONE: all outputs hold; done=1 until reset. No further vectors.
- LFSR step: Galois right shift, polynomial x^64+x^63+x^61+x^60+1.
  - Next state = (s>>1) ^ (s[0] ? 64'hD800000000000000 : 0).
- Latency: the first vector appears on data at the first rising edge after Rst deasserts with En=1.
- exp_valid:
  - Registered shift pipe of depth DELAY fed by data_valid.
  - DELAY=0: exp_valid is combinationally equal to data_valid.
  - Every data_valid beat yields exactly one exp_valid beat DELAY cycles later, including pause gaps.
- Width: data is the low DATAWIDTH bits of the LFSR, no sign manipulation. count is unsigned and cannot wrap because NUM_VECTORS is less than 2^32.
- Rst asserted mid-stream:
  - Immediate return to reset values.
  - In-flight exp_valid beats are discarded, not emitted.
  - The stream restarts from SEED.
- En toggling on the final vector: the vector is issued only on an edge with En=1, and the transition to DRAIN happens on that edge.

Optional Feature:
- Macro: STIM_CORNER_EN.
- Defined: the first four issued vectors, in order, are:
  - 0
  - -1 (all ones)
  - maximum positive (0 followed by ones)
  - minimum negative (1 followed by zeros)
- While corner vectors are issued:
  - The LFSR does not advance.
  - The fifth vector is LFSR[DATAWIDTH-1:0] of SEED.
  - Corner vectors count toward NUM_VECTORS.
  - If NUM_VECTORS < 4, only the first NUM_VECTORS corners are issued.
- Undefined: there is no corner logic and the first vector is from SEED.

Test Plan:
- Default params, En=1 held, Rst released at 100 ns, no STIM_CORNER_EN:
  - 1st edge: data=32'h89ABCDEF, data_valid=1, count=1.
  - 2nd edge: data=32'hC4D5E6F7, count=2.
  - exp_valid first high 2 cycles after data_valid.
- NUM_VECTORS=3, DELAY=2:
  - data_valid high for 3 cycles, then 0.
  - exp_valid high for 3 cycles starting 2 edges later.
  - done rises on the edge after the last exp_valid beat leaves the pipe. count=3 is held.
- En low for cycles 2-4 of the stream:
  - data holds 32'h89ABCDEF and data_valid=0 for the whole pause.
  - After the pause, next data=32'hC4D5E6F7.
  - The exp_valid gap mirrors the pause shifted by 2.
- Rst asserted asynchronously mid-stream at count=5:
  - All outputs are 0 within the same time step.
  - After release, the first vector is 32'h89ABCDEF again and no stale exp_valid beat appears.
- STIM_CORNER_EN defined, DATAWIDTH=8:
  - data sequence is 8'h00, 8'hFF, 8'h7F, 8'h80, then 8'hEF, 8'hF7.
- SEED=0, DATAWIDTH=64:
  - First vector is 64'h1.
  - Second vector is 64'hD800000000000000.
